can_tx_serializer: RTL and testbench

Serializes the message chosen by the transmit priority buffer into a CAN 2.0A base-format bit stream on `tx_bit`. It computes CRC-15, inserts stuff bits, checks each transmitted bit against `rx_bit`, and pulses `tx_done` after a successfully acknowledged frame. It sits directly downstream of `can_tx_priority`: it consumes `start_tx`, `tx_id`, `tx_dlc` and `tx_data`, and returns the `tx_done` that frees the buffer slot. Bit-timing ticks come from the bit-timing block; error frames and error counters belong to the error-handling block.

---
 rtl/can_tx_serializer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_can_tx_serializer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_serializer.sv
// CAN 2.0A base-format data-frame transmitter: serializes ID/DLC/data, appends CRC-15,
// stuffs bits, monitors the bus and reports completion, arbitration loss, bit and ACK errors.
module can_tx_serializer (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_tx,
    input  logic [10:0]     tx_id,
    input  logic [3:0]      tx_dlc,
    input  logic [7:0][7:0] tx_data,
    input  logic            bus_idle,
    input  logic            tx_point,
    input  logic            sample_point,
    input  logic            rx_bit,
    output logic            tx_bit,
    output logic            tx_busy,
    output logic            tx_done,
    output logic            arb_lost,
    output logic            bit_err,
    output logic            ack_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_CTRL,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK_SLOT,
        S_ACK_DEL,
        S_EOF,
        S_IFS
    } state_t;

    localparam logic [14:0] CRC_POLY = 15'h4599;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [14:0]    crc_q, crc_d;
    logic [2:0]     run_q, run_d;
    logic           stuff_q, stuff_d;
    logic           tx_bit_d, busy_d, done_d;
    logic           arb_lost_d, bit_err_d, ack_err_d;
    logic           load;

    logic [10:0]    id_q;
    logic [3:0]     dlc_q;
    logic [7:0][7:0] data_q;

    state_t         adv_state;
    logic [5:0]     adv_cnt;
    logic           adv_bit;
    logic           adv_done;
    logic           dlc_zero;
    logic [2:0]     last_byte;
    logic [5:0]     data_last;
    logic           in_stuff_zone;
    logic           mismatch;

    // DLC values 9..15 still carry eight data bytes.
    assign dlc_zero  = (dlc_q == 4'd0);
    assign last_byte = dlc_q[3] ? 3'd7 : 3'(dlc_q[2:0] - 3'd1);
    assign data_last = {last_byte, 3'b111};

    assign in_stuff_zone = (state_q == S_ARB) || (state_q == S_CTRL) ||
                           (state_q == S_DATA) || (state_q == S_CRC);
    assign mismatch      = (rx_bit != tx_bit);

    // Field position following the current (non-stuff) bit.
    always_comb begin
        adv_state = state_q;
        adv_cnt   = cnt_q + 6'd1;
        adv_done  = 1'b0;
        case (state_q)
            S_ARB: begin
                if (cnt_q == 6'd12) begin
                    adv_state = S_CTRL;
                    adv_cnt   = '0;
                end
            end
            S_CTRL: begin
                if (cnt_q == 6'd5) begin
                    adv_state = dlc_zero ? S_CRC : S_DATA;
                    adv_cnt   = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == data_last) begin
                    adv_state = S_CRC;
                    adv_cnt   = '0;
                end
            end
            S_CRC: begin
                if (cnt_q == 6'd14) begin
                    adv_state = S_CRC_DEL;
                    adv_cnt   = '0;
                end
            end
            S_CRC_DEL: begin
                adv_state = S_ACK_SLOT;
                adv_cnt   = '0;
            end
            S_ACK_SLOT: begin
                adv_state = S_ACK_DEL;
                adv_cnt   = '0;
            end
            S_ACK_DEL: begin
                adv_state = S_EOF;
                adv_cnt   = '0;
            end
            S_EOF: begin
                if (cnt_q == 6'd6) begin
                    adv_state = S_IFS;
                    adv_cnt   = '0;
                end
            end
            S_IFS: begin
                if (cnt_q == 6'd2) begin
                    adv_state = S_IDLE;
                    adv_cnt   = '0;
                    adv_done  = 1'b1;
                end
            end
            default: begin
                adv_state = S_IDLE;
                adv_cnt   = '0;
            end
        endcase
    end

    // Bus level of the field bit at the advanced position.
    always_comb begin
        adv_bit = 1'b1;
        case (adv_state)
            S_ARB: begin
                if (adv_cnt == 6'd12) adv_bit = 1'b0;
                else                  adv_bit = id_q[4'(4'd11 - adv_cnt[3:0])];
            end
            S_CTRL: begin
                if (adv_cnt < 6'd2) adv_bit = 1'b0;
                else                adv_bit = dlc_q[2'(3'd5 - adv_cnt[2:0])];
            end
            S_DATA:  adv_bit = data_q[adv_cnt[5:3]][3'd7 - adv_cnt[2:0]];
            S_CRC:   adv_bit = crc_q[4'(4'd14 - adv_cnt[3:0])];
            default: adv_bit = 1'b1;
        endcase
    end

    // NOTE: every signal assigned here gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        run_d      = run_q;
        stuff_d    = stuff_q;
        tx_bit_d   = tx_bit;
        busy_d     = tx_busy;
        done_d     = 1'b0;
        arb_lost_d = 1'b0;
        bit_err_d  = 1'b0;
        ack_err_d  = 1'b0;
        load       = 1'b0;

        if (state_q == S_IDLE) begin
            if (tx_point && start_tx && bus_idle) begin
                load     = 1'b1;
                state_d  = S_ARB;
                cnt_d    = '0;
                tx_bit_d = 1'b0;
                busy_d   = 1'b1;
                crc_d    = '0;  // SOF is 0, so the CRC stays at its zero seed
                run_d    = 3'd1;
                stuff_d  = 1'b0;
            end
        end else if (sample_point && ((state_q == S_ACK_SLOT) ? rx_bit : mismatch)) begin
            if (state_q == S_ACK_SLOT) begin
                ack_err_d = 1'b1;
            end else if (state_q == S_ARB && !stuff_q && cnt_q != 6'd0 && tx_bit && !rx_bit) begin
                arb_lost_d = 1'b1;
            end else begin
                bit_err_d = 1'b1;
            end
            state_d  = S_IDLE;
            cnt_d    = '0;
            crc_d    = '0;
            run_d    = '0;
            stuff_d  = 1'b0;
            tx_bit_d = 1'b1;
            busy_d   = 1'b0;
        end else if (tx_point) begin
            if (in_stuff_zone && run_q == 3'd5) begin
                tx_bit_d = ~tx_bit;
                stuff_d  = 1'b1;
                run_d    = 3'd1;
            end else if (adv_done) begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                crc_d    = '0;
                run_d    = '0;
                stuff_d  = 1'b0;
                tx_bit_d = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end else begin
                state_d  = adv_state;
                cnt_d    = adv_cnt;
                tx_bit_d = adv_bit;
                stuff_d  = 1'b0;
                if (adv_state == S_ARB || adv_state == S_CTRL ||
                    adv_state == S_DATA || adv_state == S_CRC) begin
                    run_d = (adv_bit == tx_bit) ? run_q + 3'd1 : 3'd1;
                end else begin
                    run_d = '0;
                end
                if (adv_state == S_ARB || adv_state == S_CTRL || adv_state == S_DATA) begin
                    crc_d = {crc_q[13:0], 1'b0} ^ ((adv_bit ^ crc_q[14]) ? CRC_POLY : 15'h0000);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            crc_q    <= '0;
            run_q    <= '0;
            stuff_q  <= 1'b0;
            tx_bit   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            arb_lost <= 1'b0;
            bit_err  <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            run_q    <= run_d;
            stuff_q  <= stuff_d;
            tx_bit   <= tx_bit_d;
            tx_busy  <= busy_d;
            tx_done  <= done_d;
            arb_lost <= arb_lost_d;
            bit_err  <= bit_err_d;
            ack_err  <= ack_err_d;
        end
    end

    // NOTE: the message copy has no reset; it is only read after a start has loaded it.
    always_ff @(posedge clk) begin
        if (load) begin
            id_q   <= tx_id;
            dlc_q  <= tx_dlc;
            data_q <= tx_data;
        end
    end

endmodule

// File: tb/tb_can_tx_serializer.sv
// Scoreboard bench for can_tx_serializer: a reference frame builder queues the expected
// bus stream and each transmitted bit is popped and compared as the DUT drives it.
module tb_can_tx_serializer;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_tx;
    logic [10:0]     tx_id;
    logic [3:0]      tx_dlc;
    logic [7:0][7:0] tx_data;
    logic            bus_idle;
    logic            tx_point;
    logic            sample_point;
    logic            rx_bit;
    logic            tx_bit;
    logic            tx_busy;
    logic            tx_done;
    logic            arb_lost;
    logic            bit_err;
    logic            ack_err;

    can_tx_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tx     (start_tx),
        .tx_id        (tx_id),
        .tx_dlc       (tx_dlc),
        .tx_data      (tx_data),
        .bus_idle     (bus_idle),
        .tx_point     (tx_point),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .tx_bit       (tx_bit),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .arb_lost     (arb_lost),
        .bit_err      (bit_err),
        .ack_err      (ack_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;

    logic exp_q[$];
    logic got_q[$];
    int   ack_idx, data_pos, n_stuff, n_bytes_exp;

    int   bit_idx = 0;
    int   sof_cnt = 0;
    int   done_at = -1;
    int   force_idx = -1;
    logic force_val = 1'b0;
    logic ack_val = 1'b0;

    int   cnt_done, cnt_arb, cnt_berr, cnt_aerr;
    logic evt, ev_tx_bit, ev_busy;

    task automatic clear_counts();
        cnt_done = 0;
        cnt_arb  = 0;
        cnt_berr = 0;
        cnt_aerr = 0;
        done_at  = -1;
        evt      = 1'b0;
    endtask

    // Reference frame: unstuffed bits, CRC over SOF..data, stuffing over SOF..CRC, fixed tail.
    task automatic load_expected(input logic [10:0] id, input logic [3:0] dlc,
                                 input logic [7:0][7:0] data);
        logic        raw[$];
        logic [14:0] crc;
        logic        last;
        int          run;
        exp_q.delete();
        got_q.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        repeat (3) raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        n_bytes_exp = (dlc > 4'd8) ? 8 : int'(dlc);
        for (int b = 0; b < n_bytes_exp; b++)
            for (int i = 7; i >= 0; i--) raw.push_back(data[b][i]);
        crc = '0;
        foreach (raw[k]) crc = {crc[13:0], 1'b0} ^ ((raw[k] ^ crc[14]) ? 15'h4599 : 15'h0000);
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        n_stuff  = 0;
        run      = 0;
        last     = 1'b1;
        data_pos = -1;
        foreach (raw[k]) begin
            if (k == 19) data_pos = exp_q.size();
            exp_q.push_back(raw[k]);
            if (run > 0 && raw[k] == last) run++;
            else begin
                run  = 1;
                last = raw[k];
            end
            if (run == 5) begin
                exp_q.push_back(!last);
                last = !last;
                run  = 1;
                n_stuff++;
            end
        end
        ack_idx = exp_q.size() + 1;
        repeat (13) exp_q.push_back(1'b1);
    endtask

    task automatic step(input logic tp, input logic sp);
        tx_point     = tp;
        sample_point = sp;
        @(posedge clk);
        #1;
        tx_point     = 1'b0;
        sample_point = 1'b0;
        if (tx_done)  begin cnt_done++; evt = 1'b1; ev_tx_bit = tx_bit; ev_busy = tx_busy; end
        if (arb_lost) begin cnt_arb++;  evt = 1'b1; ev_tx_bit = tx_bit; ev_busy = tx_busy; end
        if (bit_err)  begin cnt_berr++; evt = 1'b1; ev_tx_bit = tx_bit; ev_busy = tx_busy; end
        if (ack_err)  begin cnt_aerr++; evt = 1'b1; ev_tx_bit = tx_bit; ev_busy = tx_busy; end
    endtask

    // One 8-clock bit time: tx_point on clock 0, sample_point on clock 5.
    task automatic bit_period();
        logic prev_busy;
        logic e;
        prev_busy = tx_busy;
        step(1'b1, 1'b0);
        if (tx_busy && !prev_busy) begin
            bit_idx = 0;
            sof_cnt++;
        end else if (prev_busy) begin
            bit_idx++;
        end
        if (tx_done) done_at = bit_idx;
        if (tx_busy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard bit %0d: got %b, no bit expected", bit_idx, tx_bit);
            end else begin
                e = exp_q.pop_front();
                if (tx_bit !== e)
                    $display("FAIL scoreboard bit %0d: got %b, expected %b", bit_idx, tx_bit, e);
                else
                    n_pass++;
            end
            got_q.push_back(tx_bit);
            if (bit_idx == force_idx)    rx_bit = force_val;
            else if (bit_idx == ack_idx) rx_bit = ack_val;
            else                         rx_bit = tx_bit;
        end else begin
            rx_bit = tx_bit;
        end
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
    endtask

    task automatic run_until_event(input int budget);
        evt = 1'b0;
        for (int i = 0; i < budget && !evt; i++) bit_period();
    endtask

    task automatic send(input logic [10:0] id, input logic [3:0] dlc, input logic [7:0][7:0] data);
        clear_counts();
        load_expected(id, dlc, data);
        tx_id    = id;
        tx_dlc   = dlc;
        tx_data  = data;
        start_tx = 1'b1;
        bus_idle = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (tx_bit !== 1'b1) $display("FAIL reset_tx_bit: got %b, want 1", tx_bit); else n_pass++;
        n_checks++;
        if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", tx_busy); else n_pass++;
        n_checks++;
        if ({tx_done, arb_lost, bit_err, ack_err} !== 4'b0000)
            $display("FAIL reset_pulses: got %b, want 0000", {tx_done, arb_lost, bit_err, ack_err});
        else n_pass++;
        rst_n    = 1'b1;
        start_tx = 1'b1;
        bus_idle = 1'b0;
        bit_period();
        n_checks++;
        if (tx_busy !== 1'b0) $display("FAIL start_needs_idle: got busy %b, want 0", tx_busy); else n_pass++;
        start_tx = 1'b0;
    endtask

    task automatic test_basic_frame();
        logic [10:0] id_got;
        int          sofs;
        send(11'h555, 4'd0, '0);
        run_until_event(150);
        start_tx = 1'b0;
        n_checks++;
        if (cnt_done !== 1) $display("FAIL basic_done_count: got %0d, want 1", cnt_done); else n_pass++;
        n_checks++;
        if (done_at !== 47 + n_stuff)
            $display("FAIL basic_frame_len: got %0d, want %0d", done_at, 47 + n_stuff);
        else n_pass++;
        for (int i = 0; i < 11; i++) id_got[10 - i] = got_q[1 + i];
        n_checks++;
        if (id_got !== 11'h555) $display("FAIL basic_id_bits: got %h, want 555", id_got); else n_pass++;
        n_checks++;
        if (ev_busy !== 1'b0 || ev_tx_bit !== 1'b1)
            $display("FAIL basic_done_outputs: got busy %b tx %b, want 0 1", ev_busy, ev_tx_bit);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL basic_leftover: got %0d bits left, want 0", exp_q.size()); else n_pass++;
        sofs = sof_cnt;
        repeat (2) bit_period();
        n_checks++;
        if (sof_cnt !== sofs) $display("FAIL basic_no_restart: got %0d new SOFs, want 0", sof_cnt - sofs); else n_pass++;
    endtask

    task automatic test_stuffing();
        logic [7:0][7:0] d;
        d    = '0;
        d[0] = 8'hFF;
        send(11'h000, 4'd1, d);
        run_until_event(150);
        start_tx = 1'b0;
        n_checks++;
        if (got_q.size() < 6 || got_q[5] !== 1'b1)
            $display("FAIL stuff_sixth_bit: got size %0d bit %b, want 1", got_q.size(), got_q.size() > 5 ? got_q[5] : 1'bx);
        else n_pass++;
        n_checks++;
        if (done_at !== 55 + n_stuff)
            $display("FAIL stuff_frame_len: got %0d, want %0d", done_at, 55 + n_stuff);
        else n_pass++;
        n_checks++;
        if (cnt_done !== 1) $display("FAIL stuff_done_count: got %0d, want 1", cnt_done); else n_pass++;
    endtask

    task automatic test_arb_loss();
        int sofs;
        send(11'h7FF, 4'd0, '0);
        force_idx = 1;
        force_val = 1'b0;
        run_until_event(20);
        bus_idle  = 1'b0;
        force_idx = -1;
        n_checks++;
        if (cnt_arb !== 1) $display("FAIL arb_count: got %0d, want 1", cnt_arb); else n_pass++;
        n_checks++;
        if (ev_tx_bit !== 1'b1 || ev_busy !== 1'b0)
            $display("FAIL arb_outputs: got tx %b busy %b, want 1 0", ev_tx_bit, ev_busy);
        else n_pass++;
        n_checks++;
        if (cnt_done + cnt_berr !== 0) $display("FAIL arb_other_pulses: got %0d, want 0", cnt_done + cnt_berr); else n_pass++;
        load_expected(11'h7FF, 4'd0, '0);
        sofs = sof_cnt;
        repeat (3) bit_period();
        n_checks++;
        if (sof_cnt !== sofs) $display("FAIL arb_wait_idle: got %0d SOFs, want 0", sof_cnt - sofs); else n_pass++;
        bus_idle = 1'b1;
        bit_period();
        n_checks++;
        if (sof_cnt !== sofs + 1 || tx_bit !== 1'b0)
            $display("FAIL arb_retry_sof: got %0d SOFs tx %b, want 1 0", sof_cnt - sofs, tx_bit);
        else n_pass++;
        run_until_event(150);
        start_tx = 1'b0;
        n_checks++;
        if (cnt_done !== 1 || done_at !== 47 + n_stuff)
            $display("FAIL arb_retry_done: got %0d at %0d, want 1 at %0d", cnt_done, done_at, 47 + n_stuff);
        else n_pass++;
    endtask

    task automatic test_ack_error();
        send(11'h2A3, 4'd8, 64'hEFCDAB8967452301);
        ack_val = 1'b1;
        run_until_event(200);
        start_tx = 1'b0;
        ack_val  = 1'b0;
        n_checks++;
        if (cnt_aerr !== 1) $display("FAIL ack_err_count: got %0d, want 1", cnt_aerr); else n_pass++;
        n_checks++;
        if (ev_busy !== 1'b0 || ev_tx_bit !== 1'b1)
            $display("FAIL ack_err_outputs: got busy %b tx %b, want 0 1", ev_busy, ev_tx_bit);
        else n_pass++;
        n_checks++;
        if (cnt_done + cnt_berr + cnt_arb !== 0)
            $display("FAIL ack_err_other: got %0d, want 0", cnt_done + cnt_berr + cnt_arb);
        else n_pass++;
    endtask

    task automatic test_bit_error();
        send(11'h123, 4'd1, '0);
        force_idx = data_pos;
        force_val = 1'b1;
        run_until_event(150);
        start_tx  = 1'b0;
        force_idx = -1;
        n_checks++;
        if (cnt_berr !== 1) $display("FAIL bit_err_count: got %0d, want 1", cnt_berr); else n_pass++;
        n_checks++;
        if (ev_busy !== 1'b0 || ev_tx_bit !== 1'b1)
            $display("FAIL bit_err_outputs: got busy %b tx %b, want 0 1", ev_busy, ev_tx_bit);
        else n_pass++;
        n_checks++;
        if (cnt_arb + cnt_done !== 0) $display("FAIL bit_err_other: got %0d, want 0", cnt_arb + cnt_done); else n_pass++;
        n_checks++;
        if (bit_idx !== data_pos) $display("FAIL bit_err_position: got %0d, want %0d", bit_idx, data_pos); else n_pass++;
    endtask

    task automatic test_dlc_clamp();
        send(11'h3C5, 4'd15, 64'h55AA00FF1234C3F0);
        run_until_event(200);
        start_tx = 1'b0;
        n_checks++;
        if (cnt_done !== 1) $display("FAIL dlc15_done_count: got %0d, want 1", cnt_done); else n_pass++;
        n_checks++;
        if (done_at !== 111 + n_stuff)
            $display("FAIL dlc15_frame_len: got %0d, want %0d", done_at, 111 + n_stuff);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL dlc15_leftover: got %0d, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_data();
        int sofs;
        send(11'h0F0, 4'd2, '0);
        for (int i = 0; i < 60 && !(tx_busy && bit_idx >= data_pos); i++) bit_period();
        n_checks++;
        if (tx_bit !== 1'b0 || tx_busy !== 1'b1)
            $display("FAIL rst_pre_state: got tx %b busy %b, want 0 1", tx_bit, tx_busy);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_bit !== 1'b1 || tx_busy !== 1'b0)
            $display("FAIL rst_async: got tx %b busy %b, want 1 0", tx_bit, tx_busy);
        else n_pass++;
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b1;
        n_checks++;
        if (cnt_done + cnt_arb + cnt_berr + cnt_aerr !== 0)
            $display("FAIL rst_no_pulses: got %0d, want 0", cnt_done + cnt_arb + cnt_berr + cnt_aerr);
        else n_pass++;
        load_expected(11'h0F0, 4'd2, '0);
        sofs     = sof_cnt;
        bus_idle = 1'b0;
        repeat (2) bit_period();
        start_tx = 1'b0;
        bus_idle = 1'b1;
        repeat (2) bit_period();
        n_checks++;
        if (sof_cnt !== sofs) $display("FAIL rst_no_early_sof: got %0d SOFs, want 0", sof_cnt - sofs); else n_pass++;
        start_tx = 1'b1;
        bit_period();
        n_checks++;
        if (sof_cnt !== sofs + 1 || tx_bit !== 1'b0)
            $display("FAIL rst_fresh_sof: got %0d SOFs tx %b, want 1 0", sof_cnt - sofs, tx_bit);
        else n_pass++;
        run_until_event(150);
        start_tx = 1'b0;
        n_checks++;
        if (cnt_done !== 1 || done_at !== 63 + n_stuff)
            $display("FAIL rst_refresh_done: got %0d at %0d, want 1 at %0d", cnt_done, done_at, 63 + n_stuff);
        else n_pass++;
    endtask

    initial begin
        rst_n        = 1'b0;
        start_tx     = 1'b0;
        tx_id        = '0;
        tx_dlc       = '0;
        tx_data      = '0;
        bus_idle     = 1'b0;
        tx_point     = 1'b0;
        sample_point = 1'b0;
        rx_bit       = 1'b1;
        clear_counts();
        test_reset();
        test_basic_frame();
        test_stuffing();
        test_arb_loss();
        test_ack_error();
        test_bit_error();
        test_dlc_clamp();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
